// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: branch offer handshake and resolution outputs between decode/ALU and the resolve unit
interface branch_resolve_unit_if;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_op;
    logic [25:0] br_imm;
    logic [31:0] pc_plus4;
    logic        zero_bit;
    logic        redirect;
    logic [31:0] pc_target;
    logic        flush;
    logic        resolved;
    logic        op_err;
    logic [15:0] taken_cnt;
    modport master (
        output br_valid, br_op, br_imm, pc_plus4, zero_bit,
        input  br_ready, redirect, pc_target, flush, resolved, op_err, taken_cnt
    );
    modport slave (
        input  br_valid, br_op, br_imm, pc_plus4, zero_bit,
        output br_ready, redirect, pc_target, flush, resolved, op_err, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves beq/bne/j one cycle after acceptance, then redirects fetch and holds flush
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;
    localparam logic [2:0] LAST = 3'(FLUSH_CYCLES - 1);
    state_t      r_state;
    logic [1:0]  r_op;
    logic [25:0] r_imm;
    logic [31:0] r_pc;
    logic [31:0] r_pc_target;
    logic        r_redirect;
    logic        r_flush;
    logic        r_resolved;
    logic        r_op_err;
    logic [15:0] r_taken_cnt;
    logic [2:0]  r_fcnt;
    logic        w_taken;
    logic [31:0] w_target;
    always_comb begin
        w_taken  = (r_op == 2'b10) || (r_op == 2'b00 && bus.zero_bit) || (r_op == 2'b01 && !bus.zero_bit);
        w_target = r_op[1] ? {r_pc[31:28], r_imm, 2'b00} : r_pc + {{14{r_imm[15]}}, r_imm[15:0], 2'b00};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pc_target <= '0;
            r_redirect  <= 1'b0;
            r_flush     <= 1'b0;
            r_resolved  <= 1'b0;
            r_op_err    <= 1'b0;
            r_taken_cnt <= '0;
            r_fcnt      <= '0;
        end else begin
            r_redirect <= 1'b0;
            r_resolved <= 1'b0;
            r_op_err   <= 1'b0;
            case (r_state)
                IDLE: if (bus.br_valid) begin
                    r_op    <= bus.br_op;
                    r_imm   <= bus.br_imm;
                    r_pc    <= bus.pc_plus4;
                    r_state <= RESOLVE;
                end
                RESOLVE: if (w_taken) begin
                    r_state     <= REDIRECT;
                    r_pc_target <= w_target;
                    r_redirect  <= 1'b1;
                    r_flush     <= 1'b1;
                    r_fcnt      <= LAST;
                    r_resolved  <= (LAST == 3'd0);
                    r_taken_cnt <= r_taken_cnt + 16'd1;
                end else begin
                    r_state    <= IDLE;
                    r_resolved <= 1'b1;
                    r_op_err   <= (r_op == 2'b11);
                end
                // resolved is registered one cycle ahead so it lands on the last flush cycle
                REDIRECT: if (r_fcnt == 3'd0) begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                end else begin
                    r_fcnt     <= r_fcnt - 3'd1;
                    r_resolved <= (r_fcnt == 3'd1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.br_ready  = (r_state == IDLE);
    assign bus.redirect  = r_redirect;
    assign bus.pc_target = r_pc_target;
    assign bus.flush     = r_flush;
    assign bus.resolved  = r_resolved;
    assign bus.op_err    = r_op_err;
    assign bus.taken_cnt = r_taken_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed corner cases plus randomized branches against a behavioural model
module tb_branch_resolve_unit;
    localparam int F = 2;
    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] cnt_m;
    logic [31:0] last_tgt;
    branch_resolve_unit_if bus();
    branch_resolve_unit #(.FLUSH_CYCLES(F)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_br(input logic [1:0] op, input logic [25:0] imm, input logic [31:0] pc,
                         input logic zb, input logic hold);
        logic tk;
        logic [31:0] tgt;
        int off;
        tk  = (op == 2'd2) || (op == 2'd0 && zb) || (op == 2'd1 && !zb);
        off = int'($signed(imm[15:0]));
        tgt = (op == 2'd2) ? ((pc & 32'hF000_0000) | (32'(imm) * 32'd4)) : pc + 32'(off * 4);
        chk("ready_idle", 32'(bus.br_ready), 32'd1);
        bus.br_valid = 1'b1;
        bus.br_op    = op;
        bus.br_imm   = imm;
        bus.pc_plus4 = pc;
        bus.zero_bit = !zb;
        @(posedge clk);
        #1;
        bus.br_valid = hold;
        bus.br_op    = 2'($urandom);
        bus.br_imm   = 26'($urandom);
        bus.pc_plus4 = $urandom;
        bus.zero_bit = zb;
        @(negedge clk);
        chk("ready_resolve", 32'(bus.br_ready), 32'd0);
        chk("redirect_resolve", 32'(bus.redirect), 32'd0);
        chk("resolved_resolve", 32'(bus.resolved), 32'd0);
        @(posedge clk);
        #1;
        bus.zero_bit = !zb;
        @(negedge clk);
        if (tk) begin
            cnt_m++;
            last_tgt = tgt;
            chk("redirect", 32'(bus.redirect), 32'd1);
            chk("pc_target", bus.pc_target, tgt);
            chk("flush_first", 32'(bus.flush), 32'd1);
            chk("taken_cnt", 32'(bus.taken_cnt), 32'(cnt_m));
            chk("op_err_taken", 32'(bus.op_err), 32'd0);
            chk("resolved_first", 32'(bus.resolved), 32'(F == 1));
            chk("ready_redirect", 32'(bus.br_ready), 32'd0);
            for (int k = 1; k < F; k++) begin
                @(negedge clk);
                chk("redirect_pulse", 32'(bus.redirect), 32'd0);
                chk("flush_hold", 32'(bus.flush), 32'd1);
                chk("resolved_last", 32'(bus.resolved), 32'(k == F - 1));
                chk("ready_flush", 32'(bus.br_ready), 32'd0);
                chk("target_hold", bus.pc_target, tgt);
            end
            @(negedge clk);
            chk("flush_end", 32'(bus.flush), 32'd0);
            chk("resolved_end", 32'(bus.resolved), 32'd0);
            chk("ready_back", 32'(bus.br_ready), 32'd1);
            chk("taken_cnt_end", 32'(bus.taken_cnt), 32'(cnt_m));
        end else begin
            chk("redirect_nt", 32'(bus.redirect), 32'd0);
            chk("flush_nt", 32'(bus.flush), 32'd0);
            chk("resolved_nt", 32'(bus.resolved), 32'd1);
            chk("op_err_nt", 32'(bus.op_err), 32'(op == 2'd3));
            chk("ready_nt", 32'(bus.br_ready), 32'd1);
            chk("taken_cnt_nt", 32'(bus.taken_cnt), 32'(cnt_m));
            chk("target_keep", bus.pc_target, last_tgt);
        end
        bus.br_valid = 1'b0;
    endtask
    initial begin
        cnt_m        = '0;
        last_tgt     = '0;
        reset        = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_op    = '0;
        bus.br_imm   = '0;
        bus.pc_plus4 = '0;
        bus.zero_bit = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.br_ready), 32'd1);
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_target", bus.pc_target, 32'd0);
        chk("rst_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst_resolved", 32'(bus.resolved), 32'd0);
        chk("rst_op_err", 32'(bus.op_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_br(2'd0, 26'h0004, 32'h0040_0010, 1'b1, 1'b0);
        chk("beq_target", bus.pc_target, 32'h0040_0020);
        chk("beq_cnt", 32'(bus.taken_cnt), 32'd1);
        do_br(2'd1, 26'h000FFFF, 32'h0000_0008, 1'b0, 1'b0);
        chk("bne_target", bus.pc_target, 32'h0000_0004);
        do_br(2'd1, 26'h000FFFF, 32'h0000_0008, 1'b1, 1'b0);
        do_br(2'd2, 26'h0000100, 32'hA000_0000, 1'b0, 1'b0);
        chk("j_target", bus.pc_target, 32'hA000_0400);
        do_br(2'd3, 26'h0001234, 32'h1000_0000, 1'b1, 1'b0);
        do_br(2'd0, 26'h0000010, 32'h0000_1000, 1'b0, 1'b1);
        force dut.r_taken_cnt = 16'hFFFF;
        #1;
        release dut.r_taken_cnt;
        cnt_m = 16'hFFFF;
        @(negedge clk);
        do_br(2'd0, 26'h0000008, 32'h0000_2000, 1'b1, 1'b1);
        chk("cnt_wrap", 32'(bus.taken_cnt), 32'd0);
        for (int i = 0; i < 40; i++)
            do_br(2'($urandom_range(0, 3)), 26'($urandom), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        bus.br_valid = 1'b1;
        bus.br_op    = 2'd2;
        bus.br_imm   = 26'h0000040;
        bus.pc_plus4 = 32'h3000_0000;
        @(posedge clk);
        #1 bus.br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
        chk("pre_rst_flush", 32'(bus.flush), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_flush", 32'(bus.flush), 32'd0);
        chk("arst_redirect", 32'(bus.redirect), 32'd0);
        chk("arst_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("arst_target", bus.pc_target, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        cnt_m    = '0;
        last_tgt = '0;
        chk("post_rst_ready", 32'(bus.br_ready), 32'd1);
        chk("post_rst_redirect", 32'(bus.redirect), 32'd0);
        do_br(2'd2, 26'h0000001, 32'h5000_0000, 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(bus.taken_cnt), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, setting the number of cycles flush is held after a taken branch; legal range is 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port br_valid, input, 1 bit: a branch or jump is offered this cycle.
REQ-005 The block SHALL have port br_ready, output, 1 bit: the block accepts an offer this cycle.
REQ-006 The block SHALL have port br_op, input, 2 bits: 00 beq, 01 bne, 10 j, 11 reserved.
REQ-007 The block SHALL have port br_imm, input, 26 bits: bits [15:0] are the branch offset in words; bits [25:0] are the jump index.
REQ-008 The block SHALL have port pc_plus4, input, 32 bits: PC+4 of the branch instruction.
REQ-009 The block SHALL have port zero_bit, input, 1 bit: the ALU zero flag, 1 when the 32-bit ALU result is all zeros.
REQ-010 The block SHALL have port redirect, output, 1 bit: a single-cycle pulse telling the fetch stage to load pc_target.
REQ-011 The block SHALL have port pc_target, output, 32 bits: the resolved target, valid while redirect=1.
REQ-012 The block SHALL have port flush, output, 1 bit: the younger instructions in fetch/decode are squashed.
REQ-013 The block SHALL have port resolved, output, 1 bit: a single-cycle pulse marking the end of each accepted branch, whether taken or not taken.
REQ-014 The block SHALL have port op_err, output, 1 bit: a single-cycle pulse when a reserved br_op is resolved.
REQ-015 The block SHALL have port taken_cnt, output, 16 bits: the number of taken branches; wraps from 0xFFFF to 0x0000.

Function
REQ-016 The block SHALL use the FSM states IDLE, RESOLVE and REDIRECT.
REQ-017 The block SHALL drive br_ready=1 only in IDLE.
REQ-018 In IDLE, when br_valid=1, the block SHALL latch br_op, br_imm and pc_plus4 and move to RESOLVE on the next cycle.
REQ-019 While not in IDLE, the block SHALL ignore br_valid.
REQ-020 In RESOLVE, the block SHALL sample zero_bit in that cycle, one cycle after acceptance, and take no other zero_bit value.
REQ-021 The taken decision SHALL be: beq taken when zero_bit=1; bne taken when zero_bit=0; j always taken; reserved never taken.
REQ-022 For beq and bne, the block SHALL form pc_target = latched pc_plus4 + (sign-extend(br_imm[15:0]) << 2), computed modulo 2^32 with no overflow flag.
REQ-023 For j, the block SHALL form pc_target = {pc_plus4[31:28], br_imm[25:0], 2'b00}.
REQ-024 On a RESOLVE that is not taken, the block SHALL pulse resolved for one cycle, return to IDLE on the next cycle, and leave redirect and flush at 0.
REQ-025 On a RESOLVE with a reserved op, the block SHALL also pulse op_err in the same cycle as resolved.
REQ-026 On a taken RESOLVE, the block SHALL register pc_target and enter REDIRECT.
REQ-027 On the first REDIRECT cycle, the block SHALL drive redirect=1 and increment taken_cnt by 1.
REQ-028 In REDIRECT, the block SHALL hold flush=1 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter.
REQ-029 The block SHALL pulse resolved on the last flush cycle and enter IDLE on the next cycle.
REQ-030 Latency from acceptance to redirect SHALL be 2 cycles; a back-to-back offer SHALL be accepted no earlier than the first IDLE cycle.
REQ-031 pc_target SHALL hold its last value when redirect=0.

Reset
REQ-032 Assertion of reset SHALL immediately force state IDLE, redirect=0, flush=0, resolved=0, op_err=0, pc_target=0x00000000, taken_cnt=0x0000 and the flush counter to 0, regardless of the clock.
REQ-033 A reset asserted mid-RESOLVE or mid-REDIRECT SHALL abort the branch with no redirect pulse and no taken_cnt increment after reset.
REQ-034 On the first edge after reset deassertion, the block SHALL be able to accept an offer (br_ready=1).

Verification
REQ-035 The bench SHALL drive beq with pc_plus4=0x00400010, imm=0x0004 and zero_bit=1 in RESOLVE, and check redirect at +2 cycles with pc_target=0x00400020, flush high for 2 cycles, and taken_cnt=1.
REQ-036 The bench SHALL drive bne with imm=0xFFFF, pc_plus4=0x00000008 and zero_bit=0, and check pc_target=0x00000004; with zero_bit=1 it SHALL check resolved only, with no redirect and no flush.
REQ-037 The bench SHALL drive j with pc_plus4=0xA0000000 and br_imm=0x0000100, and check pc_target=0xA0000400.
REQ-038 The bench SHALL issue br_op=11, and check that op_err and resolved pulse together, with no redirect and taken_cnt unchanged.
REQ-039 The bench SHALL preload 0xFFFF taken branches and then issue one more taken beq, and check taken_cnt=0x0000; the bench SHALL hold br_valid high during REDIRECT and check that no second acceptance occurs until IDLE.
REQ-040 The bench SHALL assert reset in the first REDIRECT cycle, and check that flush and redirect drop asynchronously, taken_cnt=0, and br_ready=1 after reset release.
